gon: RTL and testbench

Global output network: the return path of the PE array. It collects one data word at a time from the PE whose configured row/column IDs match the controller-supplied tags and forwards it to the output SRAM port through a 2-entry elastic buffer. It sits between the PE array (many valid/ready sources) and the SRAM write side (a single valid/ready sink). It uses the same scan-chain ID configuration scheme as the input network, so one controller schedule addresses both directions.

---
 rtl/gon.sv | 119 +++++++++++
 tb/tb_gon.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gon.sv
// Global output network: routes one word per cycle from the tag-matched PE
// into a 2-entry elastic buffer that feeds the output SRAM write port.
module gon #(
  parameter int NUMS_PE_ROW = 6,
  parameter int NUMS_PE_COL = 8,
  parameter int XID_BITS    = 5,
  parameter int YID_BITS    = 3,
  parameter int DATA_BITS   = 32
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]           PE_valid,
  output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]           PE_ready,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL*DATA_BITS-1:0] PE_data,
  input  logic [XID_BITS-1:0]                        tag_X,
  input  logic [YID_BITS-1:0]                        tag_Y,
  input  logic                                       set_XID,
  input  logic [XID_BITS-1:0]                        XID_scan_in,
  input  logic                                       set_YID,
  input  logic [YID_BITS-1:0]                        YID_scan_in,
  output logic                                       GON_valid,
  input  logic                                       GON_ready,
  output logic [DATA_BITS-1:0]                       GON_data
);

  localparam int NPE      = NUMS_PE_ROW * NUMS_PE_COL;
  localparam int SEL_BITS = (NPE > 1) ? $clog2(NPE) : 1;

  logic [YID_BITS-1:0]  r_yid [NUMS_PE_ROW];
  logic [XID_BITS-1:0]  r_xid [NPE];
  logic [DATA_BITS-1:0] r_mem [2];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_count;

  logic [NPE-1:0]       w_match;
  logic [SEL_BITS-1:0]  w_sel;
  logic                 w_hit;
  logic                 w_can_accept;
  logic                 w_push;
  logic                 w_pop;
  logic [DATA_BITS-1:0] w_push_data;

  // ID scan chains: entry 0 takes the scan input, every other entry its predecessor.
  genvar gi;
  generate
    for (gi = 0; gi < NUMS_PE_ROW; gi++) begin : g_yid
      always_ff @(posedge clk) begin
        if (rst) begin
          r_yid[gi] <= '0;
        end else if (set_YID) begin
          if (gi == 0) r_yid[gi] <= YID_scan_in;
          else         r_yid[gi] <= r_yid[(gi > 0) ? gi - 1 : 0];
        end
      end
    end

    for (gi = 0; gi < NPE; gi++) begin : g_xid
      always_ff @(posedge clk) begin
        if (rst) begin
          r_xid[gi] <= '0;
        end else if (set_XID) begin
          if (gi == 0) r_xid[gi] <= XID_scan_in;
          else         r_xid[gi] <= r_xid[(gi > 0) ? gi - 1 : 0];
        end
      end
      assign w_match[gi] = (r_yid[gi / NUMS_PE_COL] == tag_Y) && (r_xid[gi] == tag_X);
    end
  endgenerate

  // Fixed priority: scanning downwards leaves the lowest matching index selected.
  always_comb begin
    w_sel = '0;
    w_hit = 1'b0;
    for (int k = NPE - 1; k >= 0; k--) begin
      if (w_match[k]) begin
        w_sel = SEL_BITS'(k);
        w_hit = 1'b1;
      end
    end
  end

  // Ready is a function of occupancy only, never of GON_ready.
  assign w_can_accept = (r_count < 2'd2) && !set_XID && !set_YID;

  always_comb begin
    PE_ready = '0;
    if (w_hit && w_can_accept) PE_ready[w_sel] = 1'b1;
  end

  assign w_push      = w_hit && w_can_accept && PE_valid[w_sel];
  assign w_pop       = GON_valid && GON_ready;
  assign w_push_data = PE_data[w_sel*DATA_BITS +: DATA_BITS];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign GON_valid = (r_count != 2'd0);
  assign GON_data  = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_gon.sv
// Randomised and directed bench for gon: an ID/tag reference model feeds a
// scoreboard queue that a negedge monitor checks against the DUT outputs.
module tb_gon;
  localparam int R   = 6;
  localparam int C   = 8;
  localparam int XB  = 5;
  localparam int YB  = 3;
  localparam int DB  = 32;
  localparam int NPE = R * C;

  logic              clk = 1'b0;
  logic              rst;
  logic [NPE-1:0]    PE_valid;
  logic [NPE-1:0]    PE_ready;
  logic [NPE*DB-1:0] PE_data;
  logic [XB-1:0]     tag_X;
  logic [YB-1:0]     tag_Y;
  logic              set_XID;
  logic [XB-1:0]     XID_scan_in;
  logic              set_YID;
  logic [YB-1:0]     YID_scan_in;
  logic              GON_valid;
  logic              GON_ready;
  logic [DB-1:0]     GON_data;

  gon #(.NUMS_PE_ROW(R), .NUMS_PE_COL(C), .XID_BITS(XB), .YID_BITS(YB), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .PE_valid(PE_valid), .PE_ready(PE_ready), .PE_data(PE_data),
    .tag_X(tag_X), .tag_Y(tag_Y), .set_XID(set_XID), .XID_scan_in(XID_scan_in),
    .set_YID(set_YID), .YID_scan_in(YID_scan_in), .GON_valid(GON_valid),
    .GON_ready(GON_ready), .GON_data(GON_data)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  bit mon_en = 1'b0;

  // Reference model state: ID tables and the queue of accepted words in order.
  logic [YB-1:0] m_yid [R];
  logic [XB-1:0] m_xid [NPE];
  logic [DB-1:0] sb [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Ready is granted to the lowest-index PE whose row and column IDs equal the tags,
  // provided the buffer has room and no ID chain is being shifted.
  function automatic logic [NPE-1:0] exp_ready();
    logic [NPE-1:0] r;
    r = '0;
    if (sb.size() >= 2 || set_XID || set_YID) return r;
    for (int k = 0; k < NPE; k++) begin
      if (m_yid[k / C] == tag_Y && m_xid[k] == tag_X) begin
        r[k] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
      for (int i = 0; i < R; i++) m_yid[i] = '0;
      for (int i = 0; i < NPE; i++) m_xid[i] = '0;
    end else begin
      logic [NPE-1:0] er;
      bit pop;
      er  = exp_ready();
      pop = (sb.size() != 0) && GON_ready;
      if (pop) void'(sb.pop_front());
      for (int k = 0; k < NPE; k++)
        if (er[k] && PE_valid[k]) sb.push_back(PE_data[k*DB +: DB]);
      if (set_YID) begin
        for (int i = R - 1; i > 0; i--) m_yid[i] = m_yid[i-1];
        m_yid[0] = YID_scan_in;
      end
      if (set_XID) begin
        for (int i = NPE - 1; i > 0; i--) m_xid[i] = m_xid[i-1];
        m_xid[0] = XID_scan_in;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("pe_ready", 64'(PE_ready), 64'(exp_ready()));
      chk("gon_valid", 64'(GON_valid), 64'(sb.size() != 0));
      if (GON_valid && sb.size() != 0) begin
        chk("gon_data", 64'(GON_data), 64'(sb[0]));
        if (GON_ready) $display("out word %h", GON_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic do_config();
    for (int i = 0; i < R; i++) begin
      set_YID = 1'b1;
      YID_scan_in = YB'(R - 1 - i);
      step();
    end
    set_YID = 1'b0;
    for (int k = 0; k < NPE; k++) begin
      set_XID = 1'b1;
      XID_scan_in = XB'((NPE - 1 - k) % C);
      step();
    end
    set_XID = 1'b0;
  endtask

  logic [NPE-1:0] one_hot;

  initial begin
    one_hot = '0;
    one_hot[0] = 1'b1;
    rst = 1'b1; PE_valid = '0; PE_data = '0; tag_X = '0; tag_Y = '0;
    set_XID = 1'b0; XID_scan_in = '0; set_YID = 1'b0; YID_scan_in = '0; GON_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    mon_en = 1'b1;
    at_neg();
    chk("reset_valid", 64'(GON_valid), 64'd0);
    chk("reset_data", 64'(GON_data), 64'd0);
    chk("reset_ready", 64'(PE_ready), 64'(one_hot));

    // Config and route
    do_config();
    tag_Y = 3'd2; tag_X = 5'd3; GON_ready = 1'b1;
    PE_valid[19] = 1'b1; PE_data[19*DB +: DB] = 32'hDEADBEEF;
    at_neg();
    chk("route_ready", 64'(PE_ready), 64'(one_hot << 19));
    step();
    PE_valid = '0;
    at_neg();
    chk("route_valid", 64'(GON_valid), 64'd1);
    chk("route_data", 64'(GON_data), 64'hDEADBEEF);
    step();

    // Backpressure
    GON_ready = 1'b0;
    PE_valid[19] = 1'b1; PE_data[19*DB +: DB] = 32'h1;
    step();
    PE_data[19*DB +: DB] = 32'h2;
    step();
    PE_data[19*DB +: DB] = 32'h3;
    at_neg();
    chk("bp_full_ready", 64'(PE_ready[19]), 64'd0);
    step();
    GON_ready = 1'b1;
    at_neg();
    chk("bp_out1", 64'(GON_data), 64'h1);
    step();
    at_neg();
    chk("bp_out2", 64'(GON_data), 64'h2);
    step();
    PE_valid = '0;
    at_neg();
    chk("bp_out3_valid", 64'(GON_valid), 64'd1);
    chk("bp_out3", 64'(GON_data), 64'h3);
    step();
    at_neg();
    chk("bp_empty", 64'(GON_valid), 64'd0);

    // No match
    tag_Y = 3'd7;
    PE_valid = '1;
    for (int i = 0; i < 10; i++) begin
      at_neg();
      chk("nomatch_ready", 64'(PE_ready), 64'd0);
      chk("nomatch_valid", 64'(GON_valid), 64'd0);
      step();
    end
    PE_valid = '0;

    // Config blocks traffic
    tag_Y = 3'd2; tag_X = 5'd3; GON_ready = 1'b0;
    PE_valid[19] = 1'b1; PE_data[19*DB +: DB] = 32'h55;
    step();
    set_XID = 1'b1; XID_scan_in = 5'd9; PE_data[19*DB +: DB] = 32'h66;
    at_neg();
    chk("cfg_block_ready", 64'(PE_ready), 64'd0);
    step();
    set_XID = 1'b0; PE_valid = '0; GON_ready = 1'b1;
    at_neg();
    chk("cfg_drain", 64'(GON_data), 64'h55);
    step();
    at_neg();
    chk("cfg_drained", 64'(GON_valid), 64'd0);

    // Randomised traffic on a freshly configured array
    do_config();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc % 4 == 0) begin
        tag_Y = YB'($urandom_range(0, 6));
        tag_X = XB'($urandom_range(0, 8));
      end
      PE_valid = {16'($urandom), $urandom};
      for (int k = 0; k < NPE; k++) PE_data[k*DB +: DB] = $urandom;
      GON_ready   = ($urandom % 4) != 0;
      set_XID     = ($urandom % 40) == 0;
      XID_scan_in = XB'($urandom_range(0, 7));
      set_YID     = ($urandom % 80) == 0;
      YID_scan_in = YB'($urandom_range(0, 5));
      step();
    end
    PE_valid = '0; set_XID = 1'b0; set_YID = 1'b0; GON_ready = 1'b1;
    step(); step(); step();

    // Mid-operation reset with a full buffer
    do_config();
    tag_Y = 3'd2; tag_X = 5'd3; GON_ready = 1'b0;
    PE_valid[19] = 1'b1; PE_data[19*DB +: DB] = 32'hAAAA0001;
    step();
    PE_data[19*DB +: DB] = 32'hAAAA0002;
    step();
    PE_valid = '0;
    at_neg();
    chk("mid_full_valid", 64'(GON_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; tag_X = '0; tag_Y = '0; GON_ready = 1'b1;
    at_neg();
    chk("mid_rst_valid", 64'(GON_valid), 64'd0);
    chk("mid_rst_data", 64'(GON_data), 64'd0);
    chk("mid_rst_ready", 64'(PE_ready), 64'(one_hot));
    step(); step();

    // Priority among identical IDs after reset
    PE_valid[0] = 1'b1; PE_valid[5] = 1'b1;
    PE_data[0*DB +: DB] = 32'hA0; PE_data[5*DB +: DB] = 32'hA5;
    at_neg();
    chk("prio_ready0", 64'(PE_ready[0]), 64'd1);
    chk("prio_ready5", 64'(PE_ready[5]), 64'd0);
    step();
    PE_valid = '0;
    at_neg();
    chk("prio_first", 64'(GON_data), 64'hA0);
    step(); step();

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
